// File: rtl/filter_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : filter_sched_if
// Purpose  : Pixel stream, filter-bank fan-out/fan-in and status bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface filter_sched_if #(
  parameter int N_FILTERS = 4
);
  logic                      data_valid_in;
  logic [15:0]               pixel_data_in;
  logic [10:0]               hcount_in;
  logic [9:0]                vcount_in;
  logic [2:0]                sel_in;
  logic                      bypass_in;
  logic [N_FILTERS-1:0]      filt_valid_out;
  logic [15:0]               filt_pixel_out;
  logic [10:0]               filt_hcount_out;
  logic [9:0]                filt_vcount_out;
  logic [N_FILTERS-1:0]      filt_valid_in;
  logic [16*N_FILTERS-1:0]   filt_pixel_in;
  logic [11*N_FILTERS-1:0]   filt_hcount_in;
  logic [10*N_FILTERS-1:0]   filt_vcount_in;
  logic                      data_valid_out;
  logic [15:0]               pixel_data_out;
  logic [10:0]               hcount_out;
  logic [9:0]                vcount_out;
  logic [2:0]                active_sel_out;
  logic                      busy_out;

  modport slave (
    input  data_valid_in, pixel_data_in, hcount_in, vcount_in, sel_in, bypass_in,
    input  filt_valid_in, filt_pixel_in, filt_hcount_in, filt_vcount_in,
    output filt_valid_out, filt_pixel_out, filt_hcount_out, filt_vcount_out,
    output data_valid_out, pixel_data_out, hcount_out, vcount_out,
    output active_sel_out, busy_out
  );

  modport master (
    output data_valid_in, pixel_data_in, hcount_in, vcount_in, sel_in, bypass_in,
    output filt_valid_in, filt_pixel_in, filt_hcount_in, filt_vcount_in,
    input  filt_valid_out, filt_pixel_out, filt_hcount_out, filt_vcount_out,
    input  data_valid_out, pixel_data_out, hcount_out, vcount_out,
    input  active_sel_out, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/filter_sched.sv
`default_nettype none
// ============================================================================
// Module   : filter_sched
// Purpose  : Frame-synchronous router sharing one pixel stream among N filters.
// Revision : 1.0 - initial release
// ============================================================================
module filter_sched #(
  parameter int N_FILTERS    = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  wire logic       clk_in,
  input  wire logic       rst_in,
  filter_sched_if.slave   bus
);
  localparam int          CW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [2:0]  C_BYP       = 3'(N_FILTERS);
  localparam logic [CW-1:0] C_DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_RUN    = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_active_sel, w_active_nxt;
  logic [2:0]           r_out_sel, w_out_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 w_route_en;

  logic [N_FILTERS-1:0] r_filt_valid, w_filt_valid;
  logic                 r_byp_valid;
  logic [15:0]          r_fpix;
  logic [10:0]          r_fh;
  logic [9:0]           r_fv;

  logic                 r_dv_out, w_dv;
  logic [15:0]          r_pix_out, w_pix;
  logic [10:0]          r_h_out, w_h;
  logic [9:0]           r_v_out, w_v;

  logic [2:0]           w_req;
  logic                 w_fs;
  logic                 w_route_valid;

  assign w_req = (bus.bypass_in || (bus.sel_in >= C_BYP)) ? C_BYP : bus.sel_in;
  assign w_fs  = bus.data_valid_in && (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active_sel;
    w_out_nxt    = r_out_sel;
    w_cnt_nxt    = r_cnt;
    w_route_en   = 1'b1;
    case (r_state)
      S_WAIT: begin
        w_route_en = w_fs;
        if (w_fs) begin
          w_active_nxt = w_req;
          w_out_nxt    = w_req;
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (w_fs && (w_req != r_active_sel)) begin
          w_active_nxt = w_req;
          w_cnt_nxt    = C_DRAIN_LAST;
          w_state_nxt  = S_SWITCH;
        end
      end
      S_SWITCH: begin
        // Frame starts seen here are deliberately ignored; the request is
        // re-evaluated at the first frame start back in RUN.
        if (r_cnt == '0) begin
          w_out_nxt   = r_active_sel;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // The frame-start pixel is routed with the selection it establishes.
  assign w_route_valid = bus.data_valid_in && w_route_en;

  for (genvar i = 0; i < N_FILTERS; i++) begin : g_route
    assign w_filt_valid[i] = w_route_valid && (w_active_nxt == 3'(i));
  end

  always_comb begin
    w_dv  = r_byp_valid;
    w_pix = r_fpix;
    w_h   = r_fh;
    w_v   = r_fv;
    for (int i = 0; i < N_FILTERS; i++) begin
      if (r_out_sel == 3'(i)) begin
        w_dv  = bus.filt_valid_in[i];
        w_pix = bus.filt_pixel_in[16*i +: 16];
        w_h   = bus.filt_hcount_in[11*i +: 11];
        w_v   = bus.filt_vcount_in[10*i +: 10];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state      <= S_WAIT;
      r_active_sel <= 3'd0;
      r_out_sel    <= 3'd0;
      r_cnt        <= '0;
      r_filt_valid <= '0;
      r_byp_valid  <= 1'b0;
      r_fpix       <= 16'd0;
      r_fh         <= 11'd0;
      r_fv         <= 10'd0;
      r_dv_out     <= 1'b0;
      r_pix_out    <= 16'd0;
      r_h_out      <= 11'd0;
      r_v_out      <= 10'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_sel <= w_active_nxt;
      r_out_sel    <= w_out_nxt;
      r_cnt        <= w_cnt_nxt;
      r_filt_valid <= w_filt_valid;
      r_byp_valid  <= w_route_valid && (w_active_nxt == C_BYP);
      r_fpix       <= bus.pixel_data_in;
      r_fh         <= bus.hcount_in;
      r_fv         <= bus.vcount_in;
      if (r_state == S_WAIT) begin
        r_dv_out  <= 1'b0;
        r_pix_out <= 16'd0;
        r_h_out   <= 11'd0;
        r_v_out   <= 10'd0;
      end else begin
        r_dv_out  <= w_dv;
        r_pix_out <= w_pix;
        r_h_out   <= w_h;
        r_v_out   <= w_v;
      end
    end
  end

  assign bus.filt_valid_out  = r_filt_valid;
  assign bus.filt_pixel_out  = r_fpix;
  assign bus.filt_hcount_out = r_fh;
  assign bus.filt_vcount_out = r_fv;
  assign bus.data_valid_out  = r_dv_out;
  assign bus.pixel_data_out  = r_pix_out;
  assign bus.hcount_out      = r_h_out;
  assign bus.vcount_out      = r_v_out;
  assign bus.active_sel_out  = r_active_sel;
  assign bus.busy_out        = (r_state != S_RUN);
endmodule
`default_nettype wire

// File: tb/tb_filter_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_sched
// Purpose  : Directed self-checking bench for filter_sched with 3-cycle filter stubs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r_force = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  filter_sched_if #(.N_FILTERS(N)) bus ();

  filter_sched #(.N_FILTERS(N), .DRAIN_CYCLES(8)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Filter stubs: three-stage delay of valid/coordinates, fixed pixel per filter.
  logic [N-1:0] d1 = '0, d2 = '0, d3 = '0;
  logic [10:0]  h1 = '0, h2 = '0, h3 = '0;
  logic [9:0]   v1 = '0, v2 = '0, v3 = '0;

  always @(posedge clk) begin
    d1 <= bus.filt_valid_out;  d2 <= d1;  d3 <= d2;
    h1 <= bus.filt_hcount_out; h2 <= h1;  h3 <= h2;
    v1 <= bus.filt_vcount_out; v2 <= v1;  v3 <= v2;
  end

  always_comb begin
    bus.filt_valid_in  = d3 | {N{r_force}};
    bus.filt_pixel_in  = '0;
    bus.filt_hcount_in = '0;
    bus.filt_vcount_in = '0;
    for (int i = 0; i < N; i++) begin
      bus.filt_pixel_in[16*i +: 16]  = 16'h1230 + 16'(2*i);
      bus.filt_hcount_in[11*i +: 11] = h3;
      bus.filt_vcount_in[10*i +: 10] = v3;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic vld, input logic [15:0] p, input logic [10:0] h, input logic [9:0] v);
    bus.data_valid_in = vld;
    bus.pixel_data_in = p;
    bus.hcount_in     = h;
    bus.vcount_in     = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    px(1'b0, 16'h0, 11'd0, 10'd0);
    bus.sel_in    = 3'd2;
    bus.bypass_in = 1'b0;
    tick();
    tick();
    check("rst_fvalid", 32'(bus.filt_valid_out), 32'h0);
    check("rst_dvout",  32'(bus.data_valid_out), 32'h0);
    check("rst_pix",    32'(bus.pixel_data_out), 32'h0);
    check("rst_asel",   32'(bus.active_sel_out), 32'h0);
    check("rst_busy",   32'(bus.busy_out), 32'h1);
    rst_n = 1'b1;

    // 1: no frame start, nothing is routed
    for (int k = 5; k <= 104; k++) begin
      px(1'b1, 16'hAAAA, 11'(k), 10'd0);
      tick();
      check("t1_fvalid", 32'(bus.filt_valid_out), 32'h0);
      check("t1_dvout",  32'(bus.data_valid_out), 32'h0);
    end
    check("t1_busy", 32'(bus.busy_out), 32'h1);

    // 2: frame start selects filter 2
    px(1'b1, 16'hF800, 11'd0, 10'd0);
    tick();
    px(1'b0, 16'h0, 11'd0, 10'd0);
    check("t2_fvalid", 32'(bus.filt_valid_out), 32'h4);
    check("t2_fpix",   32'(bus.filt_pixel_out), 32'hF800);
    check("t2_asel",   32'(bus.active_sel_out), 32'h2);
    check("t2_busy",   32'(bus.busy_out), 32'h0);
    tick(); tick(); tick();
    check("t2_dv_early", 32'(bus.data_valid_out), 32'h0);
    tick();
    check("t2_dv",  32'(bus.data_valid_out), 32'h1);
    check("t2_pix", 32'(bus.pixel_data_out), 32'h1234);
    check("t2_h",   32'(bus.hcount_out), 32'h0);
    tick();
    check("t2_dv_end", 32'(bus.data_valid_out), 32'h0);

    // 3: mid-frame request is deferred, then drain window on frame start
    bus.sel_in = 3'd1;
    px(1'b1, 16'h1111, 11'd10, 10'd5);
    tick();
    px(1'b0, 16'h0, 11'd0, 10'd0);
    check("t3_mid_fvalid", 32'(bus.filt_valid_out), 32'h4);
    check("t3_mid_h",      32'(bus.filt_hcount_out), 32'd10);
    check("t3_mid_v",      32'(bus.filt_vcount_out), 32'd5);
    check("t3_mid_asel",   32'(bus.active_sel_out), 32'h2);
    check("t3_mid_busy",   32'(bus.busy_out), 32'h0);
    for (int k = 0; k < 5; k++) tick();
    r_force = 1'b1;
    px(1'b1, 16'h2222, 11'd0, 10'd0);
    tick();
    check("t3_fs_fvalid", 32'(bus.filt_valid_out), 32'h2);
    check("t3_fs_asel",   32'(bus.active_sel_out), 32'h1);
    check("t3_fs_busy",   32'(bus.busy_out), 32'h1);
    check("t3_fs_pix",    32'(bus.pixel_data_out), 32'h1234);
    for (int k = 1; k <= 8; k++) begin
      px(1'b1, 16'h2222, 11'(k), 10'd0);
      tick();
      check("t3_drain_busy", 32'(bus.busy_out), (k < 8) ? 32'h1 : 32'h0);
      check("t3_drain_pix",  32'(bus.pixel_data_out), 32'h1234);
    end
    for (int k = 9; k <= 11; k++) begin
      px(1'b1, 16'h2222, 11'(k), 10'd0);
      tick();
      check("t3_new_busy",   32'(bus.busy_out), 32'h0);
      check("t3_new_pix",    32'(bus.pixel_data_out), 32'h1232);
      check("t3_new_fvalid", 32'(bus.filt_valid_out), 32'h2);
    end
    r_force = 1'b0;
    px(1'b0, 16'h0, 11'd0, 10'd0);
    for (int k = 0; k < 5; k++) tick();

    // 4: bypass from a fresh reset, 2-cycle latency
    do_reset();
    bus.bypass_in = 1'b1;
    bus.sel_in    = 3'd0;
    px(1'b1, 16'h07E0, 11'd0, 10'd0);
    tick();
    px(1'b0, 16'h0, 11'd0, 10'd0);
    check("t4_fvalid",   32'(bus.filt_valid_out), 32'h0);
    check("t4_asel",     32'(bus.active_sel_out), 32'h4);
    check("t4_dv_early", 32'(bus.data_valid_out), 32'h0);
    tick();
    check("t4_dv",  32'(bus.data_valid_out), 32'h1);
    check("t4_pix", 32'(bus.pixel_data_out), 32'h07E0);
    check("t4_h",   32'(bus.hcount_out), 32'h0);
    check("t4_v",   32'(bus.vcount_out), 32'h0);
    tick();
    check("t4_dv_end", 32'(bus.data_valid_out), 32'h0);

    // 5: out-of-range selection behaves as bypass
    do_reset();
    bus.bypass_in = 1'b0;
    bus.sel_in    = 3'd6;
    px(1'b1, 16'h5555, 11'd0, 10'd0);
    tick();
    px(1'b0, 16'h0, 11'd0, 10'd0);
    check("t5_asel",   32'(bus.active_sel_out), 32'h4);
    check("t5_fvalid", 32'(bus.filt_valid_out), 32'h0);
    tick();
    check("t5_dv",  32'(bus.data_valid_out), 32'h1);
    check("t5_pix", 32'(bus.pixel_data_out), 32'h5555);

    // 6: reset in the middle of a drain window
    bus.sel_in = 3'd3;
    px(1'b1, 16'hABCD, 11'd0, 10'd0);
    tick();
    check("t6_fs_asel", 32'(bus.active_sel_out), 32'h3);
    check("t6_fs_busy", 32'(bus.busy_out), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      px(1'b1, 16'hABCD, 11'(k), 10'd1);
      tick();
    end
    check("t6_pre_pix",    32'(bus.pixel_data_out), 32'hABCD);
    check("t6_pre_fvalid", 32'(bus.filt_valid_out), 32'h8);
    rst_n = 1'b0;
    px(1'b1, 16'hABCD, 11'd5, 10'd1);
    tick();
    rst_n = 1'b1;
    check("t6_rst_fvalid", 32'(bus.filt_valid_out), 32'h0);
    check("t6_rst_fpix",   32'(bus.filt_pixel_out), 32'h0);
    check("t6_rst_fh",     32'(bus.filt_hcount_out), 32'h0);
    check("t6_rst_fv",     32'(bus.filt_vcount_out), 32'h0);
    check("t6_rst_dv",     32'(bus.data_valid_out), 32'h0);
    check("t6_rst_pix",    32'(bus.pixel_data_out), 32'h0);
    check("t6_rst_h",      32'(bus.hcount_out), 32'h0);
    check("t6_rst_v",      32'(bus.vcount_out), 32'h0);
    check("t6_rst_asel",   32'(bus.active_sel_out), 32'h0);
    check("t6_rst_busy",   32'(bus.busy_out), 32'h1);
    for (int k = 6; k <= 8; k++) begin
      px(1'b1, 16'hABCD, 11'(k), 10'd1);
      tick();
      check("t6_wait_fvalid", 32'(bus.filt_valid_out), 32'h0);
      check("t6_wait_pix",    32'(bus.pixel_data_out), 32'h0);
      check("t6_wait_busy",   32'(bus.busy_out), 32'h1);
    end
    bus.sel_in = 3'd0;
    px(1'b1, 16'h0F0F, 11'd0, 10'd0);
    tick();
    px(1'b0, 16'h0, 11'd0, 10'd0);
    check("t6_new_fvalid", 32'(bus.filt_valid_out), 32'h1);
    check("t6_new_asel",   32'(bus.active_sel_out), 32'h0);
    check("t6_new_busy",   32'(bus.busy_out), 32'h0);
    tick(); tick(); tick();
    check("t6_new_dv_early", 32'(bus.data_valid_out), 32'h0);
    tick();
    check("t6_new_dv",  32'(bus.data_valid_out), 32'h1);
    check("t6_new_pix", 32'(bus.pixel_data_out), 32'h1230);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
